fb_access_arbiter: RTL and testbench

Arbitrates a single-port frame buffer memory between two requesters in the `clk` domain. The write requester is the capture path: coordinate generator to address formatter to CDC FIFO. The read requester is the Mac SE scan-out engine. Reads are hard real-time and win by default. A bounded-wait guard keeps capture writes from starving, so the capture FIFO never overflows under sustained scan-out load.

---
 rtl/fb_access_arbiter.sv | 132 +++++++++++++
 tb/tb_fb_access_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Single-port frame buffer arbiter: scan-out reads win, capture writes get a bounded wait.
// Optional FB_ARB_STATS_EN adds a saturating conflict counter output.
module fb_access_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1,
    parameter int WR_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam logic [3:0] WAIT_MAX = 4'(WR_MAX_WAIT);

    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic                 wait_hit;
    logic                 wr_xfer, rd_xfer;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [MEM_LATENCY:0] ret_q, ret_d;

    // Grants are gated by reset so nothing can transfer while the block is held.
    always_comb begin
        wait_hit = (wait_cnt_q == WAIT_MAX);
        wr_gnt   = !reset && wr_req && (!rd_req || wait_hit);
        rd_gnt   = !reset && rd_req && !(wr_req && wait_hit);
        wr_xfer  = wr_req && wr_gnt;
        rd_xfer  = rd_req && rd_gnt;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!wr_req || wr_xfer) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        mem_en_d    = wr_xfer || rd_xfer;
        mem_we_d    = wr_xfer;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (wr_xfer) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end else if (rd_xfer) begin
            mem_addr_d  = rd_addr;
        end
    end

    // ret_q[k] marks a read whose command left k cycles ago; the top tap lines up with mem_rdata.
    always_comb begin
        ret_d      = {ret_q[MEM_LATENCY-1:0], rd_xfer};
        rd_valid_d = ret_q[MEM_LATENCY];
        rd_data_d  = ret_q[MEM_LATENCY] ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ret_q       <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            ret_q       <= ret_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (wr_req && rd_req && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: behavioural memory, read-return scoreboard, per-scenario tasks.
module tb_fb_access_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int MAXW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt, rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    fb_access_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .WR_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_valid = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    // Behavioural single-port RAM with LAT cycles of read latency; unwritten words read pat(addr).
    logic [DW-1:0] mem   [0:65535];
    logic          wflag [0:65535];
    logic [DW-1:0] dl    [LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]   <= mem_wdata;
            wflag[mem_addr] <= 1'b1;
        end
        dl[0] <= (wflag[mem_addr] === 1'b1) ? mem[mem_addr] : pat(mem_addr);
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
    assign mem_rdata = dl[LAT-1];

    // Reference contents, updated the moment a write transfers.
    logic [DW-1:0] ref_mem  [0:65535];
    logic          ref_flag [0:65535];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return (ref_flag[a] === 1'b1) ? ref_mem[a] : pat(a);
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            n_valid++;
            n_chk++;
            if (sb_q.size() == 0) begin
                $display("FAIL rd_valid_unexpected: rd_valid=1 data=%h at cycle %0d, required no response", rd_data, cyc);
            end else begin
                e = sb_q.pop_front();
                if (rd_data !== e.data || cyc != e.due)
                    $display("FAIL rd_return: data=%h cycle=%0d, required data=%h cycle=%0d", rd_data, cyc, e.data, e.due);
                else
                    n_pass++;
            end
        end
    end

    // Record this cycle's transfers into the model, then advance to the next negedge.
    task automatic commit_cycle();
        exp_t e;
        if (rd_req && rd_gnt) begin
            e.data = ref_rd(rd_addr);
            e.due  = cyc + 2 + LAT;
            sb_q.push_back(e);
        end
        if (wr_req && wr_gnt) begin
            ref_mem[wr_addr]  = wr_data;
            ref_flag[wr_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 16'h1234; wr_data = 8'h77; rd_addr = 16'h4321;
        @(negedge clk);
        #1;
        n_chk++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0)
            $display("FAIL reset_gnt: wr_gnt=%b rd_gnt=%b, required 0 0", wr_gnt, rd_gnt); else n_pass++;
        n_chk++; if (mem_en !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL reset_mem_en: mem_en=%b mem_we=%b, required 0 0", mem_en, mem_we); else n_pass++;
        n_chk++; if (rd_valid !== 1'b0)
            $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); else n_pass++;
        n_chk++; if (mem_addr !== 16'h0 || mem_wdata !== 8'h0 || rd_data !== 8'h0)
            $display("FAIL reset_regs: addr=%h wdata=%h rd_data=%h, required 0 0 0", mem_addr, mem_wdata, rd_data); else n_pass++;
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 8'hA5; rd_req = 1'b0;
        #1;
        n_chk++; if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0)
            $display("FAIL wr_single_gnt: wr_gnt=%b rd_gnt=%b, required 1 0", wr_gnt, rd_gnt); else n_pass++;
        commit_cycle();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 16'h0010;
        #1;
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'hA5)
            $display("FAIL wr_cmd: en=%b we=%b addr=%h wdata=%h, required 1 1 0010 a5", mem_en, mem_we, mem_addr, mem_wdata); else n_pass++;
        n_chk++; if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0)
            $display("FAIL rd_single_gnt: rd_gnt=%b wr_gnt=%b, required 1 0", rd_gnt, wr_gnt); else n_pass++;
        commit_cycle();
        rd_req = 1'b0;
        #1;
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010)
            $display("FAIL rd_cmd: en=%b we=%b addr=%h, required 1 0 0010", mem_en, mem_we, mem_addr); else n_pass++;
        commit_cycle();
        #1;
        n_chk++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0010)
            $display("FAIL idle_cmd: en=%b we=%b addr=%h, required 0 0 0010", mem_en, mem_we, mem_addr); else n_pass++;
        drain(10);
        n_chk++; if (sb_q.size() != 0)
            $display("FAIL wr_rd_drain: %0d reads outstanding, required 0", sb_q.size()); else n_pass++;
        n_chk++; if (rd_data !== 8'hA5)
            $display("FAIL wr_rd_data: rd_data=%h, required a5", rd_data); else n_pass++;
    endtask

    task automatic test_starvation();
        logic [5:0] exp_w;
        logic [5:0] rdv;
        logic [5:0] exp_w2;
        // Continuous read pressure: write wins on the 4th cycle, then reads resume.
        exp_w = 6'b101000;
        for (int c = 0; c < 6; c++) begin
            wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 8'h3C;
            rd_req = (c != 5); rd_addr = 16'(16'h0020 + c);
            #1;
            n_chk++; if (wr_gnt !== exp_w[c] || rd_gnt !== (rd_req && !exp_w[c]))
                $display("FAIL starve_c%0d: wr_gnt=%b rd_gnt=%b, required %b %b", c, wr_gnt, rd_gnt, exp_w[c], rd_req && !exp_w[c]); else n_pass++;
            commit_cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        commit_cycle();
        // Wait limit reached with rd_req low: normal write, counter cleared afterwards.
        rdv    = 6'b010111;
        exp_w2 = 6'b001000;
        for (int c = 0; c < 6; c++) begin
            wr_req = (c < 5); wr_addr = 16'h0101; wr_data = 8'hC3;
            rd_req = rdv[c]; rd_addr = 16'(16'h0030 + c);
            #1;
            n_chk++; if (wr_gnt !== exp_w2[c] || rd_gnt !== (rdv[c] && !exp_w2[c]))
                $display("FAIL maxwait_norm_c%0d: wr_gnt=%b rd_gnt=%b, required %b %b", c, wr_gnt, rd_gnt, exp_w2[c], rdv[c] && !exp_w2[c]); else n_pass++;
            commit_cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        drain(12);
        n_chk++; if (sb_q.size() != 0)
            $display("FAIL starve_drain: %0d reads outstanding, required 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_streaming();
        int v0;
        v0 = n_valid;
        for (int a = 0; a < 8; a++) begin
            rd_req = 1'b1; rd_addr = 16'(a); wr_req = 1'b0;
            #1;
            n_chk++; if (rd_gnt !== 1'b1)
                $display("FAIL stream_gnt_%0d: rd_gnt=%b, required 1", a, rd_gnt); else n_pass++;
            commit_cycle();
        end
        rd_req = 1'b0;
        drain(12);
        n_chk++; if (sb_q.size() != 0 || n_valid - v0 != 8)
            $display("FAIL stream_count: outstanding=%0d returned=%0d, required 0 8", sb_q.size(), n_valid - v0); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int v0;
        v0 = n_valid;
        rd_req = 1'b1; rd_addr = 16'h0040; wr_req = 1'b0;
        commit_cycle();
        rd_addr = 16'h0041;
        commit_cycle();
        reset = 1'b1; rd_req = 1'b0;
        sb_q.delete();
        #1;
        n_chk++; if (mem_en !== 1'b0 || rd_valid !== 1'b0 || rd_gnt !== 1'b0)
            $display("FAIL midrst_clear: mem_en=%b rd_valid=%b rd_gnt=%b, required 0 0 0", mem_en, rd_valid, rd_gnt); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_chk++; if (n_valid != v0)
            $display("FAIL midrst_no_valid: %0d responses, required 0", n_valid - v0); else n_pass++;
    endtask

    task automatic test_interleave();
        logic          pw, pr, ew, er;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        int            m_wait;
        pw = 1'b0; pr = 1'b0; m_wait = 0;
        wa = '0; ra = '0; wd = '0;
        for (int c = 0; c < 60; c++) begin
            if (!pw && $urandom_range(0, 2) != 0) begin
                pw = 1'b1; wa = 16'($urandom_range(0, 15)); wd = 8'($urandom);
            end
            if (!pr && $urandom_range(0, 3) != 0) begin
                pr = 1'b1; ra = 16'($urandom_range(0, 15));
            end
            wr_req = pw; wr_addr = wa; wr_data = wd;
            rd_req = pr; rd_addr = ra;
            ew = pw && (!pr || m_wait == MAXW);
            er = pr && !(pw && m_wait == MAXW);
            #1;
            n_chk++; if (wr_gnt !== ew || rd_gnt !== er)
                $display("FAIL mix_gnt_c%0d: wr_gnt=%b rd_gnt=%b, required %b %b", c, wr_gnt, rd_gnt, ew, er); else n_pass++;
            if (!pw || ew) m_wait = 0;
            else if (m_wait != MAXW) m_wait++;
            commit_cycle();
            if (ew) pw = 1'b0;
            if (er) pr = 1'b0;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        drain(12);
        n_chk++; if (sb_q.size() != 0)
            $display("FAIL mix_drain: %0d reads outstanding, required 0", sb_q.size()); else n_pass++;
    endtask

`ifdef FB_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            wr_req = 1'b1; wr_addr = 16'h0200; wr_data = 8'h11;
            rd_req = 1'b1; rd_addr = 16'h0201;
            commit_cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        n_chk++; if (conflict_cnt !== 16'd10)
            $display("FAIL stats_10: conflict_cnt=%h, required 000a", conflict_cnt); else n_pass++;
        dut.conflict_cnt_q = 16'hFFFE;
        commit_cycle();
        for (int c = 0; c < 3; c++) begin
            wr_req = 1'b1; rd_req = 1'b1;
            commit_cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        n_chk++; if (conflict_cnt !== 16'hFFFF)
            $display("FAIL stats_sat: conflict_cnt=%h, required ffff", conflict_cnt); else n_pass++;
        commit_cycle();
        drain(12);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_starvation();
        test_streaming();
        test_reset_mid_read();
        test_interleave();
`ifdef FB_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
